// File: rtl/axi_id_remap.sv
// Slave-port AXI ID remapper: folds {master, id} into a small table index and restores it on responses.
// Optional sticky unmatched-response error flag, enabled with `define AXI_ID_REMAP_ERR_EN.
module axi_id_remap #(
  parameter int unsigned THREAD_NUM         = 8,
  parameter int unsigned MAX_OST_PER_THREAD = 8,
  parameter int unsigned NUM_MASTER         = 8,
  parameter int unsigned NUM_MASTER_LOG2    = $clog2(NUM_MASTER),
  parameter int unsigned W_ID               = 6,
  parameter int unsigned W_RID              = $clog2(THREAD_NUM),
  parameter int unsigned W_CNT              = $clog2(MAX_OST_PER_THREAD + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       s_a_valid_i,
  output logic                       s_a_ready_o,
  input  logic [W_ID-1:0]            s_a_id_i,
  input  logic [NUM_MASTER_LOG2-1:0] s_a_master_i,
  output logic                       m_a_valid_o,
  input  logic                       m_a_ready_i,
  output logic [W_RID-1:0]           m_a_id_o,
  input  logic                       m_b_valid_i,
  output logic                       m_b_ready_o,
  input  logic [W_RID-1:0]           m_b_id_i,
  input  logic                       m_b_last_i,
  output logic                       s_b_valid_o,
  input  logic                       s_b_ready_i,
  output logic [W_ID-1:0]            s_b_id_o,
  output logic [NUM_MASTER_LOG2-1:0] s_b_master_o,
  output logic                       busy_o,
  output logic                       ost_stall_o,
  output logic                       full_stall_o,
  input  logic                       err_clr_i,
  output logic                       err_o,
  output logic [W_RID-1:0]           err_rid_o
);

  localparam logic [W_CNT-1:0] CntMax = W_CNT'(MAX_OST_PER_THREAD);

  logic [THREAD_NUM-1:0]      valid_q, valid_d;
  logic [NUM_MASTER_LOG2-1:0] master_q [THREAD_NUM];
  logic [NUM_MASTER_LOG2-1:0] master_d [THREAD_NUM];
  logic [W_ID-1:0]            id_q     [THREAD_NUM];
  logic [W_ID-1:0]            id_d     [THREAD_NUM];
  logic [W_CNT-1:0]           cnt_q    [THREAD_NUM];
  logic [W_CNT-1:0]           cnt_d    [THREAD_NUM];

  logic             hit, free_any;
  logic [W_RID-1:0] hit_idx, free_idx, sel_idx;
  logic             stall, accept, retire, rsp_hs;

  // Key match and lowest-index free slot search
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < int'(THREAD_NUM); i++) begin
      if (valid_q[i] && master_q[i] == s_a_master_i && id_q[i] == s_a_id_i) begin
        hit     = 1'b1;
        hit_idx = W_RID'(i);
      end
    end
    for (int i = int'(THREAD_NUM) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = W_RID'(i);
      end
    end
  end

  assign sel_idx      = hit ? hit_idx : free_idx;
  assign ost_stall_o  = s_a_valid_i & hit & (cnt_q[hit_idx] == CntMax);
  assign full_stall_o = s_a_valid_i & ~hit & ~free_any;
  assign stall        = ost_stall_o | full_stall_o;
  assign m_a_valid_o  = s_a_valid_i & ~stall;
  assign s_a_ready_o  = m_a_ready_i & ~stall;
  assign m_a_id_o     = sel_idx;
  assign accept       = s_a_valid_i & s_a_ready_o;

  assign s_b_valid_o  = m_b_valid_i;
  assign m_b_ready_o  = s_b_ready_i;
  // Stale key fields are forwarded even when the entry is invalid
  assign s_b_id_o     = id_q[m_b_id_i];
  assign s_b_master_o = master_q[m_b_id_i];
  assign rsp_hs       = m_b_valid_i & m_b_ready_o;
  assign retire       = rsp_hs & m_b_last_i & valid_q[m_b_id_i];

  assign busy_o = |valid_q;

  always_comb begin
    logic acc_e, ret_e;
    valid_d  = valid_q;
    master_d = master_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < int'(THREAD_NUM); i++) begin
      acc_e = accept && (sel_idx == W_RID'(i));
      ret_e = retire && (m_b_id_i == W_RID'(i));
      // Accept and retire on the same entry cancel out and keep it valid
      if (acc_e && !ret_e) begin
        if (!valid_q[i]) begin
          valid_d[i]  = 1'b1;
          master_d[i] = s_a_master_i;
          id_d[i]     = s_a_id_i;
          cnt_d[i]    = W_CNT'(1);
        end else if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + W_CNT'(1);
        end
      end else if (ret_e && !acc_e) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - W_CNT'(1);
        end
        if (cnt_q[i] == W_CNT'(1)) begin
          valid_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(THREAD_NUM); i++) begin
        master_q[i] <= '0;
        id_q[i]     <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(THREAD_NUM); i++) begin
        master_q[i] <= master_d[i];
        id_q[i]     <= id_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

`ifdef AXI_ID_REMAP_ERR_EN
  logic             err_q, err_d;
  logic [W_RID-1:0] err_rid_q, err_rid_d;
  logic             bad_rsp;

  assign bad_rsp = rsp_hs & ~valid_q[m_b_id_i];

  // A new error outranks a same-cycle clear and is then treated as the first one
  always_comb begin
    err_d     = err_q;
    err_rid_d = err_rid_q;
    if (bad_rsp) begin
      err_d = 1'b1;
      if (!err_q || err_clr_i) begin
        err_rid_d = m_b_id_i;
      end
    end else if (err_clr_i) begin
      err_d     = 1'b0;
      err_rid_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q     <= 1'b0;
      err_rid_q <= '0;
    end else begin
      err_q     <= err_d;
      err_rid_q <= err_rid_d;
    end
  end

  assign err_o     = err_q;
  assign err_rid_o = err_rid_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = 1'b0;
  assign err_rid_o      = '0;
`endif

endmodule

// File: doc/axi_id_remap.md
Name: axi_id_remap

Overview:
- Slave-side counterpart to the per-thread outstanding tracker that sits at each interconnect master port.
- Sits at an interconnect slave port. Compresses each incoming {source master, AXI ID} pair into a small remapped ID equal to a table entry index.
- Translates each returning response's remapped ID back to the original ID and source master, so the response can be routed upstream.
- Retires table entries as their responses complete.

Parameters:
- THREAD_NUM, 8, number of remap table entries; the remapped ID is the entry index.
- MAX_OST_PER_THREAD, 8, maximum outstanding transactions per entry.
- NUM_MASTER, 8, number of upstream masters.
- NUM_MASTER_LOG2, $clog2(NUM_MASTER), width of the source-master field.
- W_ID, 6, width of the original AXI ID.
- W_RID, $clog2(THREAD_NUM), width of the remapped ID.
- W_CNT, $clog2(MAX_OST_PER_THREAD+1), width of the per-entry counter.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous reset, active-high
- s_a_valid_i  input  1  upstream request valid
- s_a_ready_o  output  1  upstream request ready
- s_a_id_i  input  W_ID  original request ID
- s_a_master_i  input  NUM_MASTER_LOG2  source master index
- m_a_valid_o  output  1  downstream request valid
- m_a_ready_i  input  1  downstream request ready
- m_a_id_o  output  W_RID  remapped request ID
- m_b_valid_i  input  1  downstream response valid
- m_b_ready_o  output  1  downstream response ready
- m_b_id_i  input  W_RID  remapped response ID
- m_b_last_i  input  1  final beat of the response (tie to 1 for the write-response channel)
- s_b_valid_o  output  1  upstream response valid
- s_b_ready_i  input  1  upstream response ready
- s_b_id_o  output  W_ID  restored original ID
- s_b_master_o  output  NUM_MASTER_LOG2  restored source master
- busy_o  output  1  at least one entry in use
- ost_stall_o  output  1  request blocked, matching entry at MAX_OST_PER_THREAD
- full_stall_o  output  1  request blocked, no matching entry and no free entry
- err_clr_i  input  1  clears the error flag (feature only)
- err_o  output  1  sticky unmatched-response flag (feature only)
- err_rid_o  output  W_RID  remapped ID of the first unmatched response (feature only)

Behaviour:
- Reset is asynchronous, active-high; clock is clk_i.
- Reset values: all entries invalid, cnt=0, key fields=0. Outputs: busy_o=0, err_o=0, err_rid_o=0. All combinational outputs follow their inputs from the reset state.
- Each entry holds: valid, master, id, cnt.
- Request path is combinational, zero latency; the payload travels alongside, outside this block.
  - hit: a valid entry whose {master,id} equals {s_a_master_i, s_a_id_i}. At most one entry can hit.
  - Select: on hit, the hit index; otherwise the lowest-index invalid entry.
  - ost_stall_o = s_a_valid_i & hit & (cnt==MAX_OST_PER_THREAD).
  - full_stall_o = s_a_valid_i & ~hit & no invalid entry.
  - stall = ost_stall_o | full_stall_o.
  - m_a_valid_o = s_a_valid_i & ~stall.
  - s_a_ready_o = m_a_ready_i & ~stall.
  - m_a_id_o = selected index.
  - Accept = s_a_valid_i & s_a_ready_o. On accept to a free entry: load key, set valid, cnt=1. On accept to a hit entry: cnt+1.
- Response path is combinational pass-through.
  - s_b_valid_o = m_b_valid_i; m_b_ready_o = s_b_ready_i.
  - s_b_id_o and s_b_master_o = key of entry m_b_id_i.
  - Retire = m_b_valid_i & m_b_ready_o & m_b_last_i & entry valid. Retire decrements cnt; when cnt goes 1 to 0, valid is cleared.
  - Non-last beats never change state.
- Simultaneous accept and retire on the same entry: cnt unchanged; the entry stays valid even if cnt was 1.
- An entry freed in cycle N is not visible as free until cycle N+1; there is no same-cycle bypass for a different key.
- cnt saturates: never exceeds MAX_OST_PER_THREAD, never decrements below 0.
- A retire to an invalid entry changes no state and still forwards the response using the stale key fields.
- Upstream requests keep the same ID order per {master,id} key, because all such requests map to a single remapped ID.
- busy_o = OR of all entry valid bits, registered view (reflects state, not the current-cycle accept).

Optional Feature:
- Macro: AXI_ID_REMAP_ERR_EN.
- Defined: a response with m_b_valid_i & m_b_ready_o whose entry is invalid sets err_o on the next edge. The first such response loads err_rid_o; later ones do not overwrite it. err_clr_i clears both; if clear and a new error occur in the same cycle, the error wins.
- Not defined: no error logic; err_o and err_rid_o are tied to 0 and err_clr_i is ignored.

Test Plan:
- Reset, then request master=2 id=0x05 -> m_a_id_o=0, entry0 cnt=1, busy_o=1 next cycle. Response rid=0 last=1 -> s_b_master_o=2, s_b_id_o=0x05, busy_o=0 next cycle.
- 8 requests master=1 id=0x3 with no responses -> all m_a_id_o=0. 9th request -> ost_stall_o=1, s_a_ready_o=0. One retire -> 9th accepted the following cycle.
- 8 distinct keys fill the table; 9th distinct key -> full_stall_o=1. A key already in the table still accepts. A retire freeing entry3 -> 9th key gets m_a_id_o=3 one cycle later.
- Entry0 cnt=1; same-cycle retire rid=0 and new request with the same key -> entry0 stays valid, cnt=1, m_a_id_o=0.
- Read burst of 4 beats on rid=1 with last only on beat 4 -> cnt unchanged for beats 1-3, decremented after beat 4. s_b_ready_i=0 holds m_b_ready_o=0 and changes no state.
- With AXI_ID_REMAP_ERR_EN: response rid=6 while entry6 is invalid -> err_o=1, err_rid_o=6. A second bad rid=2 leaves err_rid_o=6. err_clr_i -> err_o=0. Without the macro: err_o stays 0.
